bitfield_sequencer: RTL

//  Drives the bit-position counter from a stream of field descriptors: splits each field length into
//  per-cycle advance chunks (max 16 bits), and issues the start/sign, extend and byte-align commands.

---
 rtl/bitfield_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bitfield_sequencer.sv
// Splits field descriptors into per-cycle counter advance commands and captures the
// counter's word records into a small first-word-fall-through result FIFO.
module bitfield_sequencer #(
  parameter int RES_DEPTH = 4,
  parameter int MAX_ADV   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       desc_valid,
  output logic       desc_ready,
  input  logic [9:0] desc_len,
  input  logic       desc_start,
  input  logic       desc_sign_loc,
  input  logic       desc_extend,
  input  logic       desc_align,
  output logic       ctr_clk_en,
  output logic [4:0] ctr_advance,
  output logic       ctr_align,
  output logic       ctr_sign_en,
  output logic       ctr_sign_loc,
  output logic       ctr_extend_en,
  input  logic [6:0] ctr_cnt_out,
  input  logic       ctr_cnt_wr,
  input  logic       ctr_sign_flag,
  input  logic       ctr_ext_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [8:0] res_data,
  output logic       busy
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [9:0]    MAX_ADV_LEN  = 10'(MAX_ADV);
  localparam logic [4:0]    MAX_ADV_STEP = 5'(MAX_ADV);
  localparam logic [AW+1:0] DEPTH_W      = (AW + 2)'(RES_DEPTH);

  typedef enum logic [1:0] {IDLE, CHUNK, ALIGN} state_t;

  state_t      state_reg;
  logic [9:0]  remaining_reg;
  logic        start_reg;
  logic        sign_loc_reg;
  logic        extend_reg;
  logic        align_reg;
  logic        first_reg;

  logic [8:0]  mem_reg [RES_DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;

  logic          pop;
  logic          push_ok;
  logic [AW+1:0] free_slots;
  logic          can_issue;
  logic          issue;
  logic          in_chunk;
  logic [4:0]    step;

  assign res_valid = (count_reg != '0);
  assign pop       = res_valid && res_ready;
  // A pop frees its slot in the same cycle, so a push into a full FIFO is safe only then.
  assign push_ok   = ctr_cnt_wr && ((count_reg != DEPTH_W[AW:0]) || pop);
  assign res_data  = mem_reg[rd_ptr_reg];

  // Two free slots: one for the record already in flight, one for this cycle's issue.
  assign free_slots = DEPTH_W - {1'b0, count_reg} + {{(AW + 1){1'b0}}, pop};
  assign can_issue  = (free_slots >= (AW + 2)'(2));

  assign in_chunk = (state_reg == CHUNK);
  assign issue    = rst && can_issue && (state_reg != IDLE);
  assign step     = (remaining_reg > MAX_ADV_LEN) ? MAX_ADV_STEP : remaining_reg[4:0];

  assign desc_ready    = rst && (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign ctr_clk_en    = issue;
  assign ctr_advance   = (issue && in_chunk) ? step : 5'd0;
  assign ctr_align     = issue && (state_reg == ALIGN);
  assign ctr_sign_en   = issue && in_chunk && first_reg && start_reg;
  assign ctr_sign_loc  = issue && in_chunk && first_reg && sign_loc_reg;
  assign ctr_extend_en = issue && in_chunk && first_reg && extend_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      start_reg     <= 1'b0;
      sign_loc_reg  <= 1'b0;
      extend_reg    <= 1'b0;
      align_reg     <= 1'b0;
      first_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (desc_valid) begin
            remaining_reg <= desc_len;
            start_reg     <= desc_start;
            sign_loc_reg  <= desc_sign_loc;
            extend_reg    <= desc_extend;
            align_reg     <= desc_align;
            first_reg     <= 1'b1;
            // A zero-length field without align is consumed with no counter activity.
            if (desc_len != 10'd0)
              state_reg <= CHUNK;
            else if (desc_align)
              state_reg <= ALIGN;
          end
        end
        CHUNK: begin
          if (issue) begin
            remaining_reg <= remaining_reg - {5'd0, step};
            first_reg     <= 1'b0;
            if (remaining_reg == {5'd0, step})
              state_reg <= align_reg ? ALIGN : IDLE;
          end
        end
        ALIGN: begin
          if (issue)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_reg[wr_ptr_reg] <= {ctr_sign_flag, ctr_ext_flag, ctr_cnt_out};
  end

endmodule
